// File: rtl/collision_check.sv
// collision_check
//   Collision detection for a two-player snake game. Each cycle, every snake
//   head is compared against the play-field walls, against the snake's own
//   body, and against every segment of the other snake. The result is one
//   registered stop flag per snake, which the game-control FSM uses to halt
//   or kill that snake.
//
//   Segment i of a snake bus sits at bits [SEG_W*i +: SEG_W], laid out as
//   {x, y}. Segment 0 is the head. The all-ones value marks an unused slot.
//   An unused slot never collides with anything.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset; clears both flags
//   snake1       snake 1 segment list (SEG_NUM segments of 2*COORD_W bits)
//   snake2       snake 2 segment list
//   should_stop1 snake 1 has collided (registered, 1-cycle latency)
//   should_stop2 snake 2 has collided (registered, 1-cycle latency)
module collision_check #(
   parameter int SEG_NUM = 16,
   parameter int COORD_W = 5,
   parameter int X_MAX   = 29,
   parameter int Y_MAX   = 23
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [SEG_NUM*2*COORD_W-1:0]   snake1,
   input  logic [SEG_NUM*2*COORD_W-1:0]   snake2,
   output logic                           should_stop1,
   output logic                           should_stop2
);

   localparam int SEG_W = 2 * COORD_W;
   localparam logic [SEG_W-1:0]   EMPTY = '1;
   localparam logic [COORD_W-1:0] X_LIM = COORD_W'(X_MAX);
   localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(Y_MAX);

   logic [SEG_W-1:0] head1, head2;
   logic [SEG_W-1:0] seg_a, seg_b;
   logic             wall1, wall2;
   logic             hit1, hit2;
   logic             next1, next2;

   always_comb begin
      head1 = snake1[SEG_W-1:0];
      head2 = snake2[SEG_W-1:0];
      seg_a = '0;
      seg_b = '0;
      hit1  = 1'b0;
      hit2  = 1'b0;

      wall1 = (head1[SEG_W-1:COORD_W] > X_LIM) || (head1[COORD_W-1:0] > Y_LIM);
      wall2 = (head2[SEG_W-1:COORD_W] > X_LIM) || (head2[COORD_W-1:0] > Y_LIM);

      // One pass over both buses covers self and cross checks. A head never
      // matches itself (index 0 is skipped for own-snake checks) but does
      // count against the other snake's head, which gives the head-on case.
      for (int unsigned i = 0; i < SEG_NUM; i++) begin
         seg_a = snake1[i*SEG_W +: SEG_W];
         seg_b = snake2[i*SEG_W +: SEG_W];
         if (seg_a != EMPTY) begin
            if ((i != 0) && (seg_a == head1)) hit1 = 1'b1;
            if (seg_a == head2)               hit2 = 1'b1;
         end
         if (seg_b != EMPTY) begin
            if ((i != 0) && (seg_b == head2)) hit2 = 1'b1;
            if (seg_b == head1)               hit1 = 1'b1;
         end
      end

      // An inactive (empty-head) snake never stops, even though its
      // all-ones head coordinates would otherwise read as a wall hit.
      next1 = (head1 != EMPTY) && (wall1 || hit1);
      next2 = (head2 != EMPTY) && (wall2 || hit2);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         should_stop1 <= 1'b0;
         should_stop2 <= 1'b0;
      end else begin
         should_stop1 <= next1;
         should_stop2 <= next2;
      end
   end

endmodule

// File: tb/tb_collision_check.sv
module tb_collision_check;

   logic         clk = 1'b0;
   logic         rst;
   logic [159:0] snake1;
   logic [159:0] snake2;
   logic         should_stop1;
   logic         should_stop2;

   int compared   = 0;
   int mismatched = 0;

   collision_check #(
      .SEG_NUM(16),
      .COORD_W(5),
      .X_MAX  (29),
      .Y_MAX  (23)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .snake1      (snake1),
      .snake2      (snake2),
      .should_stop1(should_stop1),
      .should_stop2(should_stop2)
   );

   always #5 clk = ~clk;

   // Place segment (x,y) into slot idx of a snake bus.
   function automatic logic [159:0] put(input logic [159:0] v, input int idx,
                                        input int x, input int y);
      logic [159:0] r;
      r = v;
      r[idx*10 +: 10] = {5'(x), 5'(y)};
      return r;
   endfunction

   // Reference: decode both snakes into coordinate pairs and apply the game
   // rules directly on the (x,y) points.
   function automatic logic model_stop(input logic [159:0] me, input logic [159:0] other);
      int mx[16], my[16], ox[16], oy[16];
      logic stop;
      for (int k = 0; k < 16; k++) begin
         mx[k] = int'(me[k*10+5 +: 5]);
         my[k] = int'(me[k*10 +: 5]);
         ox[k] = int'(other[k*10+5 +: 5]);
         oy[k] = int'(other[k*10 +: 5]);
      end
      if (mx[0] == 31 && my[0] == 31) return 1'b0;
      stop = (mx[0] > 29) || (my[0] > 23);
      for (int k = 1; k < 16; k++)
         if (!(mx[k] == 31 && my[k] == 31) && mx[k] == mx[0] && my[k] == my[0]) stop = 1'b1;
      for (int k = 0; k < 16; k++)
         if (!(ox[k] == 31 && oy[k] == 31) && ox[k] == mx[0] && oy[k] == my[0]) stop = 1'b1;
      return stop;
   endfunction

   task automatic check(input string tag, input logic e1, input logic e2);
      compared++;
      assert (should_stop1 === e1) else begin
         mismatched++;
         $error("FAIL %s should_stop1 observed=%b expected=%b", tag, should_stop1, e1);
      end
      compared++;
      assert (should_stop2 === e2) else begin
         mismatched++;
         $error("FAIL %s should_stop2 observed=%b expected=%b", tag, should_stop2, e2);
      end
   endtask

   // Apply inputs between edges, clock once, sample 1 time unit later.
   task automatic step(input string tag, input logic [159:0] s1, input logic [159:0] s2,
                       input logic e1, input logic e2);
      snake1 = s1;
      snake2 = s2;
      @(posedge clk);
      #1;
      check(tag, e1, e2);
   endtask

   function automatic int rand_x();
      return ($urandom_range(0, 3) == 0) ? int'($urandom_range(27, 31)) : int'($urandom_range(0, 5));
   endfunction

   function automatic int rand_y();
      return ($urandom_range(0, 3) == 0) ? int'($urandom_range(21, 25)) : int'($urandom_range(0, 5));
   endfunction

   function automatic logic [159:0] rand_snake();
      logic [159:0] v;
      v = '1;
      for (int k = 0; k < 16; k++) begin
         if (k == 0 && $urandom_range(0, 7) == 0) continue;
         if (k != 0 && $urandom_range(0, 2) == 0) continue;
         v = put(v, k, rand_x(), rand_y());
      end
      return v;
   endfunction

   initial begin
      logic [159:0] a1, a2, b1, b2, r1, r2;

      // Reset with all-zero inputs.
      rst    = 1'b1;
      snake1 = '0;
      snake2 = '0;
      @(posedge clk);
      #1;
      check("reset_hold", 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("reset_hold2", 1'b0, 1'b0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("zero_self", 1'b1, 1'b1);

      // Baseline non-colliding snakes.
      a1 = put(put('1, 0, 5, 5), 1, 4, 5);
      a2 = put(put('1, 0, 10, 10), 1, 9, 10);
      step("no_collision", a1, a2, 1'b0, 1'b0);

      // Walls.
      step("wall_x30", put(put('1, 0, 30, 5), 1, 29, 5), a2, 1'b1, 1'b0);
      step("corner_legal", put(put('1, 0, 29, 23), 1, 28, 23), a2, 1'b0, 1'b0);
      step("wall_y24", put(put('1, 0, 5, 24), 1, 5, 23), a2, 1'b1, 1'b0);
      step("wall_x30_s2", a1, put(put('1, 0, 30, 23), 1, 29, 23), 1'b0, 1'b1);

      // Self hit.
      b1 = put(put(put(put(put('1, 0, 5, 5), 1, 6, 5), 2, 6, 6), 3, 5, 6), 4, 5, 5);
      step("self_hit", b1, a2, 1'b1, 1'b0);

      // Cross hit into snake2 body.
      step("cross_body", put(put('1, 0, 9, 10), 1, 8, 10), a2, 1'b1, 1'b0);

      // Head-on.
      step("head_on", put(put('1, 0, 7, 7), 1, 6, 7), put(put('1, 0, 7, 7), 1, 8, 7), 1'b1, 1'b1);

      // Inactive snake1: never stops, its non-empty body is still an obstacle.
      step("inactive_obstacle", put('1, 1, 10, 10), a2, 1'b0, 1'b1);
      step("all_empty", '1, '1, 1'b0, 1'b0);

      // Latency: a mid-cycle change shows only after the next rising edge.
      step("latency_pre", a1, a2, 1'b0, 1'b0);
      snake1 = b1;
      #3;
      check("latency_mid", 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("latency_edge", 1'b1, 1'b0);

      // Asynchronous reset between edges.
      step("async_pre", put(put('1, 0, 7, 7), 1, 6, 7), put(put('1, 0, 7, 7), 1, 8, 7), 1'b1, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("async_drop", 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("async_hold", 1'b0, 1'b0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("async_release", 1'b1, 1'b1);

      // Randomized snakes against the reference model.
      for (int n = 0; n < 400; n++) begin
         r1 = rand_snake();
         r2 = rand_snake();
         // Sometimes force a collision onto a random slot of either snake.
         if ($urandom_range(0, 2) == 0) r2[$urandom_range(0, 15)*10 +: 10] = r1[9:0];
         if ($urandom_range(0, 3) == 0) r1[$urandom_range(1, 15)*10 +: 10] = r1[9:0];
         step("random", r1, r2, model_stop(r1, r2), model_stop(r2, r1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/collision_check.md
Name: collision_check

Overview:
- Combinational collision detection with registered outputs for a two-player snake game.
- Each cycle it compares each snake's head against the walls, its own body and the entire other snake.
- It produces one stop flag per snake.
- Sits between the snake-position registers and the game-control FSM, which halts or kills a snake when its flag is high.

Parameters:
- SEG_NUM, 16, segments per snake; bus width = SEG_NUM*2*COORD_W.
- COORD_W, 5, bits per coordinate (x and y).
- X_MAX, 29, largest legal x coordinate (inclusive).
- Y_MAX, 23, largest legal y coordinate (inclusive).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- snake1  input  160  snake 1 segment list.
- snake2  input  160  snake 2 segment list.
- should_stop1  output  1  snake 1 has collided, registered.
- should_stop2  output  1  snake 2 has collided, registered.

Behaviour:
- Segment encoding:
  - Segment i occupies bits [10i+9:10i].
  - x = bits [10i+9:10i+5], y = bits [10i+4:10i].
  - Segment 0 is the head; segments 1..15 are the body in order.
- Empty segment: the value 10'h3FF (x=31, y=31) marks an unused slot. Empty slots never collide and are ignored everywhere.
- A snake whose head is empty is inactive:
  - Its stop flag is computed as 0.
  - Its segments still count as obstacles only if they are non-empty.
- should_stop1 next-state is 1 when snake1's head is non-empty and any of these holds:
  - (a) wall: head x > X_MAX or head y > Y_MAX;
  - (b) self: head equals any non-empty snake1 segment 1..SEG_NUM-1;
  - (c) other: head equals any non-empty snake2 segment 0..SEG_NUM-1, including snake2's head.
- should_stop2 uses the symmetric rule with the snakes swapped.
- Head-on: equal non-empty heads set both flags in the same cycle.
- Comparisons are full 10-bit equality; all checks are purely combinational and evaluated in parallel.
- Outputs are registered on the rising edge of clk: latency is exactly 1 cycle from input change to flag.
- Flags are not sticky; they are recomputed every cycle from the current inputs.
- Reset:
  - rst=1 asynchronously forces should_stop1=0 and should_stop2=0.
  - Flags stay 0 while rst is high.
  - The first valid flag appears on the first rising edge after rst deasserts.
- All-zero inputs (power-up default):
  - Every segment is (0,0) and non-empty, so each head equals its own segment 1.
  - Both flags go 1 one cycle after reset release.
  - The controller must load 10'h3FF into unused slots.
- Coordinates equal to X_MAX or Y_MAX are legal; X_MAX+1 or Y_MAX+1 is a wall hit.

Test Plan:
- Reset:
  - Stimulus: rst=1 while snake1=snake2=0; pulse clk.
  - Response: both flags 0. Release rst, one edge: both flags 1 (self-collision at (0,0)).
- No collision:
  - snake1 head (5,5)=10'h0A5, body (4,5)=10'h085, rest 10'h3FF.
  - snake2 head (10,10)=10'h14A, body (9,10)=10'h12A, rest 10'h3FF.
  - Response: both flags 0 after one edge.
- Wall hit:
  - snake1 head (30,5): should_stop1=1, should_stop2=0.
  - Head (29,23): should_stop1=0.
  - Head (5,24): should_stop1=1.
- Self hit: snake1 segments (5,5),(6,5),(6,6),(5,6),(5,5) -> should_stop1=1 one cycle later, should_stop2=0.
- Cross hit and head-on:
  - snake1 head equal to snake2 segment 1 -> only should_stop1=1.
  - Both heads (7,7) -> both flags 1 on the same edge.
- Latency and async reset:
  - Change inputs to a collision mid-cycle -> flag rises only at the next rising edge.
  - Assert rst between edges -> flags drop immediately, without waiting for clk.
